// File: rtl/updown_event_counter.sv
// Modulo up/down event counter: synchronised, edge-detected countup/countdown with clear, clamped load and wrap pulses.
// Define COUNT_DEBOUNCE_EN to insert a per-input debounce stage between synchroniser and edge detector.
module updown_event_counter #(
  parameter int WIDTH           = 4,
  parameter int MODULO          = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             countup,
  input  logic             countdown,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_up,
  output logic             wrap_down
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

  if (SYNC_STAGES < 2 || MODULO < 2 || MODULO > 2**WIDTH || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("updown_event_counter: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_up, sync_dn, fill;
  logic [1:0] raw, cur, prev, armed, step;

  // fill marks when the synchroniser outputs carry real post-reset samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_up <= '0;
      sync_dn <= '0;
      fill    <= '0;
    end else begin
      sync_up <= {sync_up[SYNC_STAGES-2:0], countup};
      sync_dn <= {sync_dn[SYNC_STAGES-2:0], countdown};
      fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign raw = {sync_dn[SYNC_STAGES-1], sync_up[SYNC_STAGES-1]};

`ifdef COUNT_DEBOUNCE_EN
  typedef enum logic {STABLE, COUNTING} db_state_t;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  db_state_t       state    [2];
  db_state_t       state_nx [2];
  logic [CW-1:0]   cnt      [2];
  logic [CW-1:0]   cnt_nx   [2];
  logic [1:0]      stable, stable_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
      stable <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
      stable <= stable_nx;
    end
  end

  // the new level is taken on the DEBOUNCE_CYCLES-th consecutive differing cycle
  always_comb begin
    stable_nx = stable;
    for (int unsigned i = 0; i < 2; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      unique case (state[i])
        STABLE: begin
          if (raw[i] != stable[i]) begin
            if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
              stable_nx[i] = raw[i];
            end else begin
              cnt_nx[i]   = CW'(1);
              state_nx[i] = COUNTING;
            end
          end
        end
        COUNTING: begin
          if (raw[i] == stable[i]) begin
            cnt_nx[i]   = '0;
            state_nx[i] = STABLE;
          end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_nx[i] = raw[i];
            cnt_nx[i]    = '0;
            state_nx[i]  = STABLE;
          end else begin
            cnt_nx[i] = cnt[i] + CW'(1);
          end
        end
        default: begin
          cnt_nx[i]   = '0;
          state_nx[i] = STABLE;
        end
      endcase
    end
  end

  assign cur = stable;
`else
  assign cur = raw;
`endif

  // an edge is accepted only once a genuine low has been observed since reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= '0;
      armed <= '0;
    end else begin
      prev  <= cur;
      armed <= armed | (~raw & {2{fill[SYNC_STAGES-1]}});
    end
  end

  assign step = cur & ~prev & armed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
    end else begin
      wrap_up   <= 1'b0;
      wrap_down <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= (load_val > MAX) ? MAX : load_val;
      end else if (step[0] && !step[1]) begin
        if (count == MAX) begin
          count   <= '0;
          wrap_up <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
        end
      end else if (step[1] && !step[0]) begin
        if (count == '0) begin
          count     <= MAX;
          wrap_down <= 1'b1;
        end else begin
          count <= count - WIDTH'(1);
        end
      end
    end
  end

endmodule
